// File: rtl/sha_msg_padder_if.sv
// Bundles the word-stream input and the sha_core block handshake of the SHA-256 padder.
// Input side: a word transfers on a rising edge where in_valid & in_ready; the source holds
// in_valid/in_data/in_last/in_bytes stable until then. Core side: start pulses once per block,
// message/first_blk/last_blk hold until core_valid reports the digest done.
interface sha_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         start;
  logic [511:0] message;
  logic         first_blk;
  logic         last_blk;
  logic         core_valid;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, core_valid,
    output in_ready, start, message, first_blk, last_blk
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, core_valid,
    input  in_ready, start, message, first_blk, last_blk
  );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: collects big-endian words into 512-bit blocks, appends the 0x80
// marker, zero fill and 64-bit bit length, and issues blocks to sha_core one at a time.
module sha_msg_padder (
  input  logic                   clk,
  input  logic                   clr,
  sha_msg_padder_if.slave        bus,
  output logic                   busy,
  output logic [2:0]             state_dbg
);
  typedef enum logic [2:0] {ST_FILL, ST_PAD, ST_ISSUE, ST_WAIT, ST_EXTRA} state_t;

  state_t       state_q, state_d;
  logic [31:0]  buf_q [16];
  logic [31:0]  msg_q [16];
  logic [31:0]  pad_w [16];
  logic [511:0] msg_flat;
  logic [3:0]   wcnt_q, last_slot_q;
  logic [2:0]   last_bytes_q, bytes_c;
  logic [63:0]  bitlen_q;
  logic [4:0]   m_pos;
  logic [31:0]  keep_mask, marker_word;
  logic         first_pend_q, first_blk_q, last_blk_q, extra_q, marker_q;
  logic         wait_first_q, busy_q, accept, core_done;

  assign accept    = (state_q == ST_FILL) && clr && bus.in_valid;
  assign bytes_c   = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
  assign core_done = !wait_first_q && bus.core_valid;
  // Marker lands in the last word unless it was full, then in the following word.
  assign m_pos     = {1'b0, last_slot_q} + {4'd0, (last_bytes_q == 3'd4)};

  assign bus.in_ready  = (state_q == ST_FILL) && clr;
  assign bus.start     = (state_q == ST_ISSUE);
  assign bus.first_blk = first_blk_q;
  assign bus.last_blk  = last_blk_q;
  assign bus.message   = msg_flat;
  assign busy          = busy_q;
  assign state_dbg     = state_q;

  always_comb begin
    msg_flat = '0;
    for (int k = 0; k < 16; k++) msg_flat[511-32*k -: 32] = msg_q[k];
  end

  always_comb begin
    keep_mask   = 32'hFFFF_FFFF;
    marker_word = '0;
    case (last_bytes_q)
      3'd0: begin keep_mask = 32'h0000_0000; marker_word = 32'h8000_0000; end
      3'd1: begin keep_mask = 32'hFF00_0000; marker_word = 32'h0080_0000; end
      3'd2: begin keep_mask = 32'hFFFF_0000; marker_word = 32'h0000_8000; end
      3'd3: begin keep_mask = 32'hFFFF_FF00; marker_word = 32'h0000_0080; end
      default: ;
    endcase
    for (int k = 0; k < 16; k++) begin
      pad_w[k] = '0;
      if (k < int'(last_slot_q))       pad_w[k] = buf_q[k];
      else if (k == int'(last_slot_q)) pad_w[k] = (buf_q[k] & keep_mask) | marker_word;
      else if (k == int'(m_pos))       pad_w[k] = 32'h8000_0000;
    end
    if (m_pos <= 5'd13) begin
      pad_w[14] = bitlen_q[63:32];
      pad_w[15] = bitlen_q[31:0];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (bus.in_last)             state_d = ST_PAD;
          else if (wcnt_q == 4'd15)    state_d = ST_ISSUE;
        end
      end
      ST_PAD:   state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (core_done) state_d = extra_q ? ST_EXTRA : ST_FILL;
      ST_EXTRA: state_d = ST_ISSUE;
      default:  state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= '0;
        msg_q[k] <= '0;
      end
      wcnt_q       <= '0;
      last_slot_q  <= '0;
      last_bytes_q <= '0;
      bitlen_q     <= '0;
      first_pend_q <= 1'b1;
      first_blk_q  <= 1'b0;
      last_blk_q   <= 1'b0;
      extra_q      <= 1'b0;
      marker_q     <= 1'b0;
      wait_first_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            buf_q[wcnt_q] <= bus.in_data;
            busy_q        <= 1'b1;
            if (bus.in_last) begin
              bitlen_q     <= bitlen_q + {58'd0, bytes_c, 3'b000};
              last_slot_q  <= wcnt_q;
              last_bytes_q <= bytes_c;
            end else begin
              bitlen_q <= bitlen_q + 64'd32;
              wcnt_q   <= wcnt_q + 4'd1;
              if (wcnt_q == 4'd15) begin
                for (int k = 0; k < 15; k++) msg_q[k] <= buf_q[k];
                msg_q[15]    <= bus.in_data;
                first_blk_q  <= first_pend_q;
                first_pend_q <= 1'b0;
                last_blk_q   <= 1'b0;
                extra_q      <= 1'b0;
                marker_q     <= 1'b0;
              end
            end
          end
        end
        ST_PAD: begin
          for (int k = 0; k < 16; k++) msg_q[k] <= pad_w[k];
          first_blk_q  <= first_pend_q;
          first_pend_q <= 1'b0;
          last_blk_q   <= (m_pos <= 5'd13);
          extra_q      <= (m_pos >= 5'd14);
          marker_q     <= (m_pos == 5'd16);
        end
        ST_ISSUE: wait_first_q <= 1'b1;
        ST_WAIT: begin
          // The cycle right after start cannot carry a valid for this block.
          wait_first_q <= 1'b0;
          if (core_done) begin
            if (last_blk_q) begin
              bitlen_q     <= '0;
              wcnt_q       <= '0;
              busy_q       <= 1'b0;
              first_pend_q <= 1'b1;
            end else if (!extra_q) begin
              wcnt_q <= '0;
            end
          end
        end
        ST_EXTRA: begin
          for (int k = 1; k < 14; k++) msg_q[k] <= '0;
          msg_q[0]    <= marker_q ? 32'h8000_0000 : 32'h0000_0000;
          msg_q[14]   <= bitlen_q[63:32];
          msg_q[15]   <= bitlen_q[31:0];
          first_blk_q <= 1'b0;
          last_blk_q  <= 1'b1;
          extra_q     <= 1'b0;
          marker_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: known SHA-256 padding vectors, multi-block messages,
// back-pressure through WAIT and reset in the middle of a block.
module tb_sha_msg_padder;
  logic       clk = 1'b0;
  logic       clr;
  logic       busy;
  logic [2:0] state_dbg;
  logic [31:0] ew [16];
  int n_checks = 0;
  int n_pass   = 0;

  sha_msg_padder_if bus ();

  sha_msg_padder dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [511:0] pack_w(input logic [31:0] w [16]);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[511-32*k -: 32] = w[k];
    return r;
  endfunction

  function automatic logic [31:0] pat(input int k);
    return 32'h1020_3040 + 32'(k) * 32'h0101_0101;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  task automatic chk_msg(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic ew_clear();
    for (int k = 0; k < 16; k++) ew[k] = '0;
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_bit("in_ready_before_word", bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_block(input string tag, input logic f, input logic l);
    chk_bit({tag, "_start"}, bus.start, 1'b1);
    chk_msg({tag, "_message"}, bus.message, pack_w(ew));
    chk_bit({tag, "_first_blk"}, bus.first_blk, f);
    chk_bit({tag, "_last_blk"}, bus.last_blk, l);
  endtask

  // From the ISSUE cycle: skip the first WAIT cycle, then pulse core_valid once.
  task automatic finish_block();
    @(negedge clk);
    @(negedge clk);
    bus.core_valid = 1'b1;
    @(negedge clk);
    bus.core_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.in_bytes   = '0;
    bus.core_valid = 1'b0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_bit("rst_in_ready", bus.in_ready, 1'b0);
    chk_bit("rst_start", bus.start, 1'b0);
    chk_msg("rst_message", bus.message, 512'd0);
    chk_bit("rst_busy", busy, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    chk_bit("post_rst_in_ready", bus.in_ready, 1'b1);

    // "abc"
    ew_clear(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    chk_bit("abc_pad_no_start", bus.start, 1'b0);
    chk_bit("abc_busy", busy, 1'b1);
    @(negedge clk);
    check_block("abc", 1'b1, 1'b1);
    finish_block();
    chk_bit("abc_done_busy", busy, 1'b0);
    chk_bit("abc_done_ready", bus.in_ready, 1'b1);

    // empty message
    ew_clear(); ew[0] = 32'h8000_0000;
    send_word(32'h0000_0000, 1'b1, 3'd0);
    @(negedge clk);
    check_block("empty", 1'b1, 1'b1);
    finish_block();

    // "abcd" with in_bytes=7, treated as 4
    ew_clear(); ew[0] = 32'h6162_6364; ew[1] = 32'h8000_0000; ew[15] = 32'h0000_0020;
    send_word(32'h6162_6364, 1'b1, 3'd7);
    @(negedge clk);
    check_block("bytes7", 1'b1, 1'b1);
    finish_block();

    // "hello": marker mid-word in word 1, stale bytes masked
    ew_clear(); ew[0] = 32'h6865_6C6C; ew[1] = 32'h6F80_0000; ew[15] = 32'h0000_0028;
    send_word(32'h6865_6C6C, 1'b0, 3'd0);
    send_word(32'h6FAA_BBCC, 1'b1, 3'd1);
    @(negedge clk);
    check_block("hello", 1'b1, 1'b1);
    finish_block();

    // 56 bytes: marker in word 14, length in an extra block
    ew_clear();
    for (int k = 0; k < 14; k++) ew[k] = pat(k);
    ew[14] = 32'h8000_0000;
    for (int k = 0; k < 13; k++) send_word(pat(k), 1'b0, 3'd4);
    send_word(pat(13), 1'b1, 3'd4);
    @(negedge clk);
    check_block("b56_blk1", 1'b1, 1'b0);
    finish_block();
    chk_bit("b56_extra_no_start", bus.start, 1'b0);
    chk_bit("b56_extra_busy", busy, 1'b1);
    ew_clear(); ew[15] = 32'h0000_01C0;
    @(negedge clk);
    check_block("b56_blk2", 1'b0, 1'b1);
    finish_block();
    chk_bit("b56_done_busy", busy, 1'b0);

    // 58 bytes: marker fits in word 14, extra block carries only the length
    ew_clear();
    for (int k = 0; k < 14; k++) ew[k] = pat(k);
    ew[14] = (pat(14) & 32'hFFFF_0000) | 32'h0000_8000;
    for (int k = 0; k < 14; k++) send_word(pat(k), 1'b0, 3'd4);
    send_word(pat(14), 1'b1, 3'd2);
    @(negedge clk);
    check_block("b58_blk1", 1'b1, 1'b0);
    finish_block();
    ew_clear(); ew[15] = 32'h0000_01D0;
    @(negedge clk);
    check_block("b58_blk2", 1'b0, 1'b1);
    finish_block();

    // 64 bytes: full block unchanged, marker and length in the extra block
    ew_clear();
    for (int k = 0; k < 16; k++) ew[k] = pat(k);
    for (int k = 0; k < 15; k++) send_word(pat(k), 1'b0, 3'd4);
    send_word(pat(15), 1'b1, 3'd4);
    chk_bit("b64_pad_no_start", bus.start, 1'b0);
    @(negedge clk);
    check_block("b64_blk1", 1'b1, 1'b0);
    finish_block();
    ew_clear(); ew[0] = 32'h8000_0000; ew[15] = 32'h0000_0200;
    @(negedge clk);
    check_block("b64_blk2", 1'b0, 1'b1);
    finish_block();

    // back-pressure: next word held valid through ISSUE/WAIT
    ew_clear(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1122_3344;
    bus.in_last  = 1'b1;
    bus.in_bytes = 3'd2;
    @(negedge clk);
    check_block("bp_abc", 1'b1, 1'b1);
    chk_bit("bp_issue_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    chk_bit("bp_wait1_ready", bus.in_ready, 1'b0);
    bus.core_valid = 1'b1;
    @(negedge clk);
    chk_bit("bp_early_valid_ignored_ready", bus.in_ready, 1'b0);
    chk_bit("bp_early_valid_ignored_busy", busy, 1'b1);
    @(negedge clk);
    bus.core_valid = 1'b0;
    chk_bit("bp_exit_ready", bus.in_ready, 1'b1);
    chk_bit("bp_exit_busy", busy, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_bit("bp_word_taken", busy, 1'b1);
    chk_bit("bp_pad_ready", bus.in_ready, 1'b0);
    ew_clear(); ew[0] = 32'h1122_8000; ew[15] = 32'h0000_0010;
    @(negedge clk);
    check_block("bp_second", 1'b1, 1'b1);
    finish_block();
    chk_bit("bp_done_ready", bus.in_ready, 1'b1);

    // reset in the middle of WAIT, with core_valid pending
    ew_clear();
    for (int k = 0; k < 16; k++) ew[k] = pat(k);
    for (int k = 0; k < 16; k++) send_word(pat(k), 1'b0, 3'd4);
    check_block("rw_full", 1'b1, 1'b0);
    @(negedge clk);
    bus.core_valid = 1'b1;
    clr = 1'b0;
    #1;
    chk_bit("rw_rst_start", bus.start, 1'b0);
    chk_msg("rw_rst_message", bus.message, 512'd0);
    chk_bit("rw_rst_first", bus.first_blk, 1'b0);
    chk_bit("rw_rst_last", bus.last_blk, 1'b0);
    chk_bit("rw_rst_busy", busy, 1'b0);
    chk_bit("rw_rst_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    bus.core_valid = 1'b0;
    @(negedge clk);
    chk_bit("rw_post_ready", bus.in_ready, 1'b1);
    ew_clear(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    @(negedge clk);
    check_block("rw_abc", 1'b1, 1'b1);
    finish_block();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
